// File: rtl/brlite_local_rx.sv
// brlite_local_rx: local-port BrLite receiver; 4-phase req/ack capture into a FIFO feeding the broadcast crossbar
module brlite_local_rx #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              br_req_i,
    output logic              br_ack_o,
    input  logic [DATA_W-1:0] br_data_i,
    output logic              br_local_busy_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  accepted_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, count_nxt;
    logic push, pop;
    // full is judged on the registered count, so a same-cycle pop never makes room
    always_comb begin
        push = state == IDLE && br_req_i && count != FULL;
        pop = out_valid_o && out_ready_i;
        count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        state_nxt = state == IDLE ? (push ? HOLD : IDLE) : (br_req_i ? HOLD : IDLE);
    end
    assign out_valid_o = count != '0;
    assign out_data_o = mem[rd_ptr];
    always_ff @(posedge clk_i) if (push) mem[wr_ptr] <= br_data_i;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            br_ack_o <= 1'b0;
            br_local_busy_o <= 1'b0;
            accepted_cnt_o <= '0;
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (push) accepted_cnt_o <= accepted_cnt_o + CNT_W'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            state <= state_nxt;
            br_ack_o <= state_nxt == HOLD;
            br_local_busy_o <= count_nxt != '0 || state_nxt == HOLD;
        end
    end
endmodule
